// File: rtl/reg_access_pkg.sv
// ---------------------------------------------------------------------------
// reg_access_pkg
// Shared types and helpers for the register-access initiator.
//   state_t     : FSM state encoding (IDLE / ACCESS / WAIT / RESP), 2 bits
//   decode_t    : result of addr_decode, {hit, index}
//   addr_decode : byte address -> register index plus mapped flag
//   RD_LAT_MAX  : largest supported read-data latency
// ---------------------------------------------------------------------------
package reg_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int RD_LAT_MAX = 3;

  // Addresses are decoded at a fixed 32-bit width; callers zero-extend.
  localparam int DEC_W = 32;

  typedef struct packed {
    logic             hit;
    logic [DEC_W-1:0] index;
  } decode_t;

  // The subtraction carries one extra bit so an address below the base
  // shows up as a borrow instead of wrapping around into the register range.
  function automatic decode_t addr_decode(
    input logic [DEC_W-1:0] addr,
    input logic [DEC_W-1:0] base,
    input int unsigned      reg_num,
    input int unsigned      bytes_per_reg
  );
    logic [DEC_W:0]   diff;
    logic [DEC_W-1:0] offset;
    decode_t          d;
    diff    = {1'b0, addr} - {1'b0, base};
    offset  = diff[DEC_W-1:0];
    d.index = offset / bytes_per_reg;
    d.hit   = !diff[DEC_W] && ((offset % bytes_per_reg) == 0) && (d.index < reg_num);
    return d;
  endfunction

endpackage

// File: rtl/reg_access_fsm_if.sv
// ---------------------------------------------------------------------------
// reg_access_fsm_if
// Request/response channel between the bus bridge (master) and the
// register-access initiator (slave).
//   req_vld/req_rdy     : request handshake
//   req_wr              : 1 = write, 0 = read
//   req_addr/req_wdata  : byte address and write data
//   rsp_vld/rsp_rdy     : response handshake
//   rsp_rdata/rsp_err   : read data and error flag
// ---------------------------------------------------------------------------
interface reg_access_fsm_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reg_rd_mux.sv
// ---------------------------------------------------------------------------
// reg_rd_mux
// Combinational REG_NUM:1 selector over the packed read-back bus.
//   reg_rd_data : packed read-back, register i at slice i
//   index       : register index to select
//   rd_data     : selected slice (0 if index is beyond REG_NUM-1)
// ---------------------------------------------------------------------------
module reg_rd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 8,
  parameter int IDX_W      = 3
) (
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data,
  input  logic [IDX_W-1:0]              index,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] slices [REG_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_slice
      assign slices[gi] = reg_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Compare-and-select keeps non-power-of-two REG_NUM safe.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (index == IDX_W'(i)) rd_data = slices[i];
    end
  end

endmodule

// File: rtl/reg_access_fsm.sv
// ---------------------------------------------------------------------------
// reg_access_fsm
// Accepts one register access at a time, decodes it to a one-hot register
// select, pulses sw_wr/sw_rd for one cycle, captures read-back data and
// returns a response.
//   clk, sync_rst : clock, synchronous active-high reset
//   bus           : request/response channel (slave side)
//   sw_wr, sw_rd  : per-register write/read strobes
//   sw_wr_data    : write data to fields, zero whenever no write strobe
//   reg_rd_data   : packed read-back, register i at slice i
// ---------------------------------------------------------------------------
module reg_access_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 8,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = 0
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  reg_access_fsm_if.slave               bus,
  output logic [REG_NUM-1:0]            sw_wr,
  output logic [REG_NUM-1:0]            sw_rd,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data
);
  import reg_access_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);

  state_t                state_reg, state_next;
  logic                  wr_reg, wr_next;
  logic                  hit_reg, hit_next;
  logic [IDX_W-1:0]      index_reg, index_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;

  decode_t               dec;
  logic                  unused_dec_bits;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  active;
  logic                  resp_active;
  logic [REG_NUM-1:0]    sel;

  assign dec = addr_decode(DEC_W'(bus.req_addr), DEC_W'(BASE_ADDR), REG_NUM, BYTES);
  // Upper index bits only matter through the hit flag.
  assign unused_dec_bits = ^dec.index[DEC_W-1:IDX_W];

  reg_rd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_NUM   (REG_NUM),
    .IDX_W     (IDX_W)
  ) u_rd_mux (
    .reg_rd_data(reg_rd_data),
    .index      (index_reg),
    .rd_data    (mux_data)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      hit_reg   <= 1'b0;
      index_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wr_reg    <= wr_next;
      hit_reg   <= hit_next;
      index_reg <= index_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wr_next    = wr_reg;
    hit_next   = hit_reg;
    index_next = index_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_vld) begin
          state_next = ACCESS;
          wr_next    = bus.req_wr;
          wdata_next = bus.req_wdata;
          hit_next   = dec.hit;
          index_next = dec.index[IDX_W-1:0];
          rdata_next = '0;
          cnt_next   = '0;
        end
      end
      ACCESS: begin
        if (!wr_reg && hit_reg) begin
          if (RD_LAT > 0) begin
            state_next = WAIT;
            cnt_next   = '0;
          end else begin
            // Sampled alongside the read strobe: pre-side-effect value.
            state_next = RESP;
            rdata_next = mux_data;
          end
        end else begin
          state_next = RESP;
        end
      end
      WAIT: begin
        if (cnt_reg == CNT_W'(RD_LAT - 1)) begin
          state_next = RESP;
          rdata_next = mux_data;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so an asserted reset wins in its own cycle.
  assign active      = (state_reg == ACCESS) && hit_reg && !sync_rst;
  assign resp_active = (state_reg == RESP) && !sync_rst;
  assign sel         = REG_NUM'(1) << index_reg;

  assign sw_wr      = (active && wr_reg)  ? sel : '0;
  assign sw_rd      = (active && !wr_reg) ? sel : '0;
  assign sw_wr_data = (active && wr_reg)  ? wdata_reg : '0;

  assign bus.req_rdy   = (state_reg == IDLE) && !sync_rst;
  assign bus.rsp_vld   = resp_active;
  assign bus.rsp_rdata = resp_active ? rdata_reg : '0;
  assign bus.rsp_err   = resp_active && !hit_reg;

endmodule

// File: tb/tb_reg_access_fsm.sv
// ---------------------------------------------------------------------------
// tb_reg_access_fsm
// Directed bench for reg_access_fsm. Three instances share clock, reset and
// read-back bus: a (BASE 0, RD_LAT 0), b (BASE 0, RD_LAT 2),
// c (BASE 0x100, RD_LAT 0).
// ---------------------------------------------------------------------------
module tb_reg_access_fsm;

  logic clk;
  logic sync_rst;
  logic [8*32-1:0] rrd;

  logic [7:0]  sw_wr_a, sw_rd_a, sw_wr_b, sw_rd_b, sw_wr_c, sw_rd_c;
  logic [31:0] swd_a, swd_b, swd_c;

  int n_chk  = 0;
  int n_fail = 0;

  reg_access_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) a ();
  reg_access_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) b ();
  reg_access_fsm_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) c ();

  reg_access_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_NUM(8), .BASE_ADDR(0), .RD_LAT(0)) u_a (
    .clk(clk), .sync_rst(sync_rst), .bus(a),
    .sw_wr(sw_wr_a), .sw_rd(sw_rd_a), .sw_wr_data(swd_a), .reg_rd_data(rrd)
  );

  reg_access_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_NUM(8), .BASE_ADDR(0), .RD_LAT(2)) u_b (
    .clk(clk), .sync_rst(sync_rst), .bus(b),
    .sw_wr(sw_wr_b), .sw_rd(sw_rd_b), .sw_wr_data(swd_b), .reg_rd_data(rrd)
  );

  reg_access_fsm #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_NUM(8), .BASE_ADDR(256), .RD_LAT(0)) u_c (
    .clk(clk), .sync_rst(sync_rst), .bus(c),
    .sw_wr(sw_wr_c), .sw_rd(sw_rd_c), .sw_wr_data(swd_c), .reg_rd_data(rrd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic v, input logic w, input logic [15:0] ad, input logic [31:0] wd);
    a.req_vld = v; a.req_wr = w; a.req_addr = ad; a.req_wdata = wd;
  endtask

  task automatic req_b(input logic v, input logic w, input logic [15:0] ad, input logic [31:0] wd);
    b.req_vld = v; b.req_wr = w; b.req_addr = ad; b.req_wdata = wd;
  endtask

  task automatic req_c(input logic v, input logic w, input logic [15:0] ad, input logic [31:0] wd);
    c.req_vld = v; c.req_wr = w; c.req_addr = ad; c.req_wdata = wd;
  endtask

  initial begin
    logic [15:0] e_addr  [3];
    logic        e_wr    [3];
    logic [31:0] e_wd    [3];
    logic [7:0]  e_wrs   [3];
    logic [7:0]  e_rds   [3];
    logic [31:0] e_rdata [3];

    sync_rst = 1'b1;
    for (int i = 0; i < 8; i++) rrd[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    req_a(0, 0, 0, 0); req_b(0, 0, 0, 0); req_c(0, 0, 0, 0);
    a.rsp_rdy = 1'b1; b.rsp_rdy = 1'b1; c.rsp_rdy = 1'b1;

    // Reset state
    step; step;
    chk("rst_req_rdy", a.req_rdy, 0);
    chk("rst_rsp_vld", a.rsp_vld, 0);
    chk("rst_sw_wr", sw_wr_a, 0);
    sync_rst = 1'b0;
    #1;
    chk("post_rst_req_rdy", a.req_rdy, 1);
    chk("post_rst_rsp_rdata", a.rsp_rdata, 0);

    // Write register 1 at byte address 4
    req_a(1, 1, 16'h0004, 32'hA5A5_0001);
    step;
    req_a(0, 0, 0, 0);
    chk("wr_strobe", sw_wr_a, 8'b0000_0010);
    chk("wr_data", swd_a, 32'hA5A5_0001);
    chk("wr_no_rd", sw_rd_a, 0);
    chk("wr_early_vld", a.rsp_vld, 0);
    chk("wr_busy_rdy", a.req_rdy, 0);
    step;
    chk("wr_strobe_off", sw_wr_a, 0);
    chk("wr_data_off", swd_a, 0);
    chk("wr_rsp_vld", a.rsp_vld, 1);
    chk("wr_rsp_err", a.rsp_err, 0);
    chk("wr_rsp_rdata", a.rsp_rdata, 0);
    step;
    chk("wr_idle_rdy", a.req_rdy, 1);
    chk("wr_rsp_done", a.rsp_vld, 0);

    // Read register 7, RD_LAT 0
    rrd[7*32 +: 32] = 32'hDEAD_BEEF;
    req_a(1, 0, 16'h001C, 0);
    step;
    req_a(0, 0, 0, 0);
    chk("rd7_strobe", sw_rd_a, 8'b1000_0000);
    chk("rd7_no_wr", sw_wr_a, 0);
    step;
    chk("rd7_strobe_off", sw_rd_a, 0);
    chk("rd7_vld", a.rsp_vld, 1);
    chk("rd7_rdata", a.rsp_rdata, 32'hDEAD_BEEF);
    chk("rd7_err", a.rsp_err, 0);
    step;

    // Read register 7, RD_LAT 2: value changes during the last wait cycle
    req_b(1, 0, 16'h001C, 0);
    step;
    req_b(0, 0, 0, 0);
    chk("lat_strobe", sw_rd_b, 8'b1000_0000);
    step;
    chk("lat_w1_vld", b.rsp_vld, 0);
    chk("lat_w1_strobe", sw_rd_b, 0);
    step;
    rrd[7*32 +: 32] = 32'h0000_0001;
    chk("lat_w2_vld", b.rsp_vld, 0);
    step;
    chk("lat_vld", b.rsp_vld, 1);
    chk("lat_rdata", b.rsp_rdata, 32'h0000_0001);
    chk("lat_err", b.rsp_err, 0);
    step;
    chk("lat_idle_rdy", b.req_rdy, 1);

    // Error accesses on instance a: misaligned read, out-of-range read, misaligned write
    e_addr[0] = 16'h0002; e_wr[0] = 1'b0; e_wd[0] = 32'h0;
    e_addr[1] = 16'h0020; e_wr[1] = 1'b0; e_wd[1] = 32'h0;
    e_addr[2] = 16'h0006; e_wr[2] = 1'b1; e_wd[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      req_a(1, e_wr[k], e_addr[k], e_wd[k]);
      step;
      req_a(0, 0, 0, 0);
      chk($sformatf("err%0d_strobes", k), {sw_wr_a, sw_rd_a}, 0);
      chk($sformatf("err%0d_wdata", k), swd_a, 0);
      step;
      chk($sformatf("err%0d_vld", k), a.rsp_vld, 1);
      chk($sformatf("err%0d_err", k), a.rsp_err, 1);
      chk($sformatf("err%0d_rdata", k), a.rsp_rdata, 0);
      step;
    end

    // Instance c (base 0x100): address below base, then first mapped register above it
    req_c(1, 0, 16'h00FC, 0);
    step;
    req_c(0, 0, 0, 0);
    chk("below_strobes", {sw_wr_c, sw_rd_c}, 0);
    step;
    chk("below_vld", c.rsp_vld, 1);
    chk("below_err", c.rsp_err, 1);
    chk("below_rdata", c.rsp_rdata, 0);
    step;
    req_c(1, 0, 16'h0104, 0);
    step;
    req_c(0, 0, 0, 0);
    chk("base_rd1_strobe", sw_rd_c, 8'b0000_0010);
    step;
    chk("base_rd1_err", c.rsp_err, 0);
    chk("base_rd1_rdata", c.rsp_rdata, 32'h1000_0001);
    step;

    // Backpressure: response held for 5 cycles while a new request waits
    rrd[3*32 +: 32] = 32'h0000_0033;
    a.rsp_rdy = 1'b0;
    req_a(1, 0, 16'h000C, 0);
    step;
    req_a(1, 1, 16'h0008, 32'hCAFE_0008);
    chk("bp_strobe", sw_rd_a, 8'b0000_1000);
    step;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_vld", k), a.rsp_vld, 1);
      chk($sformatf("bp%0d_rdata", k), a.rsp_rdata, 32'h0000_0033);
      chk($sformatf("bp%0d_req_rdy", k), a.req_rdy, 0);
      chk($sformatf("bp%0d_strobes", k), {sw_wr_a, sw_rd_a}, 0);
      if (k == 0) rrd[3*32 +: 32] = 32'h0000_0077;
      if (k < 4) step;
    end
    a.rsp_rdy = 1'b1;
    step;
    chk("bp_release_rdy", a.req_rdy, 1);
    chk("bp_release_vld", a.rsp_vld, 0);
    step;
    req_a(0, 0, 0, 0);
    chk("bp_next_strobe", sw_wr_a, 8'b0000_0100);
    chk("bp_next_wdata", swd_a, 32'hCAFE_0008);
    step;
    chk("bp_next_rdata", a.rsp_rdata, 0);
    chk("bp_next_err", a.rsp_err, 0);
    step;

    // Back-to-back read r1 / write r2 / read r5 with req_vld held high
    e_addr[0] = 16'h0004; e_wr[0] = 1'b0; e_wd[0] = 32'h0;
    e_wrs[0] = 8'h00; e_rds[0] = 8'h02; e_rdata[0] = 32'h1000_0001;
    e_addr[1] = 16'h0008; e_wr[1] = 1'b1; e_wd[1] = 32'h2222_0002;
    e_wrs[1] = 8'h04; e_rds[1] = 8'h00; e_rdata[1] = 32'h0;
    e_addr[2] = 16'h0014; e_wr[2] = 1'b0; e_wd[2] = 32'h0;
    e_wrs[2] = 8'h00; e_rds[2] = 8'h20; e_rdata[2] = 32'h1000_0005;
    req_a(1, e_wr[0], e_addr[0], e_wd[0]);
    for (int i = 0; i < 9; i++) begin
      int j;
      j = i / 3;
      step;
      case (i % 3)
        0: begin
          chk($sformatf("b2b%0d_sw_wr", j), sw_wr_a, e_wrs[j]);
          chk($sformatf("b2b%0d_sw_rd", j), sw_rd_a, e_rds[j]);
          if (j < 2) req_a(1, e_wr[j+1], e_addr[j+1], e_wd[j+1]);
          else req_a(0, 0, 0, 0);
        end
        1: begin
          chk($sformatf("b2b%0d_vld", j), a.rsp_vld, 1);
          chk($sformatf("b2b%0d_rdata", j), a.rsp_rdata, e_rdata[j]);
          chk($sformatf("b2b%0d_strobes_off", j), {sw_wr_a, sw_rd_a}, 0);
        end
        default: begin
          chk($sformatf("b2b%0d_idle_rdy", j), a.req_rdy, 1);
        end
      endcase
    end

    // Reset in the acceptance cycle: no strobe, no response
    req_a(1, 1, 16'h0000, 32'h1234_5678);
    sync_rst = 1'b1;
    step;
    chk("rstp_req_rdy", a.req_rdy, 0);
    chk("rstp_sw_wr", sw_wr_a, 0);
    sync_rst = 1'b0;
    req_a(0, 0, 0, 0);
    step;
    chk("rstp_no_strobe", sw_wr_a, 0);
    chk("rstp_no_wdata", swd_a, 0);
    chk("rstp_no_vld", a.rsp_vld, 0);
    chk("rstp_rdy", a.req_rdy, 1);
    step;
    chk("rstp_no_vld2", a.rsp_vld, 0);

    // Reset while the strobe cycle is active: strobe suppressed, access dropped
    req_a(1, 1, 16'h0000, 32'h1234_5678);
    step;
    req_a(0, 0, 0, 0);
    sync_rst = 1'b1;
    #1;
    chk("rsta_strobe", sw_wr_a, 0);
    chk("rsta_wdata", swd_a, 0);
    step;
    sync_rst = 1'b0;
    #1;
    chk("rsta_vld", a.rsp_vld, 0);
    step;
    chk("rsta_vld2", a.rsp_vld, 0);
    chk("rsta_rdy", a.req_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
